// File: rtl/nios2_system_onchip_memory_ctrl.sv
// On-chip RAM slave for the Nios II system with an Avalon-MM pipelined read interface.
// After every reset a clear engine can zero-fill (or CLEAR_VALUE-fill) the whole array
// before the slave starts accepting transfers.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   reset_req, clken      RAM clock enable is clken & ~reset_req
//   address, byteenable   word address and write byte lanes
//   chipselect, read,     Avalon-MM request; a write wins over a simultaneous read
//   write, writedata
//   readdata,             read response, one-cycle valid pulse READ_LATENCY cycles
//   readdatavalid         after the accepting edge; readdata holds between pulses
//   waitrequest           stall while clearing, in reset or with the clock disabled
//   init_done             array is usable
module nios2_system_onchip_memory_ctrl #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 15,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    reset_req,
   input  logic                    clken,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   writedata,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest,
   output logic                    init_done
);

   localparam int unsigned NumLanes = DATA_WIDTH / 8;
   localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

   typedef enum logic [0:0] {StClear, StReady} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
   logic                    clocken;
   logic                    clear_we;
   logic                    accept;
   logic                    accept_read;
   logic                    accept_write;

   logic [DATA_WIDTH-1:0]   mem [Depth];
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    rd_valid_q;
   logic                    resp_valid;

   assign clocken = clken & ~reset_req;

   // Next-state logic for the clear engine; reset is applied in the state register.
   always_comb begin
      state_d      = state_q;
      clear_addr_d = clear_addr_q;
      clear_we     = 1'b0;
      unique case (state_q)
         StClear: begin
            if (clocken && !reset) begin
               clear_we = 1'b1;
               // Last location written: leave the address parked instead of wrapping.
               if (clear_addr_q == '1) begin
                  state_d = StReady;
               end else begin
                  clear_addr_d = clear_addr_q + 1'b1;
               end
            end
         end
         StReady: begin
            state_d = StReady;
         end
         default: begin
            state_d = StClear;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if (CLEAR_ON_RESET != 0) begin
            state_q <= StClear;
         end else begin
            state_q <= StReady;
         end
         clear_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         clear_addr_q <= clear_addr_d;
      end
   end

   // Reset is folded in combinationally so the slave stalls during the reset cycle itself.
   assign waitrequest  = reset | (state_q != StReady) | ~clocken;
   assign init_done    = (state_q == StReady) & ~reset;
   assign accept       = chipselect & (read | write) & ~waitrequest;
   assign accept_write = accept & write;
   assign accept_read  = accept & read & ~write;

   // Array has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem[clear_addr_q] <= CLEAR_VALUE;
      end else if (accept_write) begin
         for (int i = 0; i < NumLanes; i++) begin
            if (byteenable[i]) begin
               mem[address][8*i +: 8] <= writedata[8*i +: 8];
            end
         end
      end
   end

   // First read stage: the RAM output register, loaded only on an accepted read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= accept_read;
         if (accept_read) begin
            rd_data_q <= mem[address];
         end
      end
   end

   if (READ_LATENCY >= 2) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_data_q;
      logic                  out_valid_q;

      // Stages advance every cycle, independent of clken.
      always_ff @(posedge clk) begin
         if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
         end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
               out_data_q <= rd_data_q;
            end
         end
      end

      assign readdata   = out_data_q;
      assign resp_valid = out_valid_q;
   end else begin : g_no_out_reg
      assign readdata   = rd_data_q;
      assign resp_valid = rd_valid_q;
   end

   // Reads still in flight when reset arrives must never produce a response.
   assign readdatavalid = resp_valid & ~reset;

endmodule

// File: doc/nios2_system_onchip_memory_ctrl.md
Name: nios2_system_onchip_memory_ctrl

Overview:
Parametrised on-chip RAM slave with an Avalon-MM pipelined read interface (read, readdatavalid, waitrequest) for the Nios II system. It generalises the fixed 32x32K single-port memory in three ways:
- configurable width, depth and read latency;
- a hardware clear engine that zero-fills the array after reset;
- byte-lane writes at any width.
It sits between the system interconnect and the inferred block RAM.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8, range 8..128
ADDR_WIDTH, 15, word address width; depth = 2**ADDR_WIDTH words
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2 (2 adds an output register)
CLEAR_ON_RESET, 1, 1 = zero-fill array after every reset; 0 = skip the fill
CLEAR_VALUE, 0, word written to every location during the clear

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
reset_req  in  1  reset-request hold-off; gates the RAM clock enable
clken  in  1  clock enable from the interconnect
address  in  ADDR_WIDTH  word address
byteenable  in  DATA_WIDTH/8  write byte lanes
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_WIDTH  write data
readdata  out  DATA_WIDTH  read data; valid only when readdatavalid=1
readdatavalid  out  1  one-cycle pulse per accepted read
waitrequest  out  1  stall; the master holds the request while this is high
init_done  out  1  high once the array is usable

Behaviour:
- Clock enable: clocken = clken & ~reset_req.
- FSM states: CLEAR, READY.
  - While reset=1, or at the first edge after reset=1: state <= CLEAR if CLEAR_ON_RESET=1, else READY. clear_addr <= 0.
  - Reset values: readdata=0, readdatavalid=0, waitrequest=1, init_done=0. Every pipeline valid bit is cleared.
- CLEAR state:
  - Each cycle with clocken=1: RAM[clear_addr] <= CLEAR_VALUE (all lanes), then clear_addr increments.
  - Cycles with clocken=0 stall the fill; no address is skipped.
  - The write to clear_addr = 2**ADDR_WIDTH-1 is the last fill write. State becomes READY on the next cycle; clear_addr does not wrap.
  - Fill duration: exactly 2**ADDR_WIDTH enabled cycles.
  - waitrequest=1 and init_done=0 throughout CLEAR.
  - Reset asserted mid-fill restarts the fill at address 0.
- READY state:
  - init_done=1.
  - waitrequest = ~clocken (combinational).
  - Accept = chipselect & (read|write) & ~waitrequest.
- Write (accepted, write=1):
  - Each byte lane i with byteenable[i]=1 takes writedata[8i+7:8i] at the clock edge.
  - Lanes with byteenable[i]=0 are unchanged.
  - byteenable=0 is a legal no-op.
- Read (accepted, read=1, write=0):
  - The RAM word is captured at the accepting edge.
  - readdata and readdatavalid=1 appear exactly READ_LATENCY cycles after the accept cycle, for one cycle only.
  - Back-to-back reads sustain 1 result per cycle, returned in order.
- Pipeline:
  - Pipeline stages advance every cycle regardless of clken. clken only gates acceptance and RAM access.
  - readdata holds its last value when readdatavalid=0.
- read=1 and write=1 together: the write is performed; no read response is generated.
- Read of an address written in the previous accept cycle returns the new data (no stale read).
- chipselect=0: read and write are ignored; no response.
- Addresses are always in range; no wrap logic beyond ADDR_WIDTH.
- Reset with reads in flight: those reads are dropped; no readdatavalid is emitted for them.

Test Plan:
- Clear fill. ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5; deassert reset; hold clken=1.
  -> waitrequest=1 for 16 cycles, then init_done=1 and waitrequest=0.
  -> Reads of addresses 0..15 all return 32'hA5A5A5A5.
- Byte lanes. Write 32'h11223344 to address 3 with byteenable=4'b1111; then write 32'hFFFFFFFF with byteenable=4'b0101.
  -> A read of address 3 returns 32'h11FF33FF.
- Read latency. READ_LATENCY=2; accept reads of addresses 1, 2, 3 on consecutive cycles.
  -> readdatavalid is high on cycles +2, +3, +4 relative to the first accept, with data in order.
  -> READ_LATENCY=1 gives cycles +1, +2, +3.
- Stall.
  - reset_req=1 for 3 cycles during READY -> waitrequest=1 and no write occurs.
  - clken=0 during CLEAR at clear_addr=5 -> the fill resumes at 5 with no gap.
- Reset mid-fill. Assert reset at clear_addr=9 -> clear_addr=0 next cycle; the full 16-cycle fill repeats before init_done=1.
- Reset in flight. Accept a read; assert reset the next cycle.
  -> readdatavalid stays 0.
  -> Simultaneous read+write to address 7 with 32'hDEADBEEF: no response; a later read of address 7 returns 32'hDEADBEEF.
